// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states and operation kind.
// Latency: n/a (types only).
// Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum bit {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    function automatic logic isBusyState(input state_t s);
        return (s == PREP) || (s == RUN) || (s == FIX);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Launch/result bundle between the control unit and muldiv_seq; abort exists only with MULDIV_ABORT_EN.
// Latency: n/a (wiring only).
// Backpressure: none; starts are ignored while busy.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_ABORT_EN
    logic             abort;
`endif

    modport master (
        output start_mult, start_div, is_signed, a, b,
`ifdef MULDIV_ABORT_EN
        output abort,
`endif
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, is_signed, a, b,
`ifdef MULDIV_ABORT_EN
        input  abort,
`endif
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: res = (val ^ {inv}) + inc; inv=inc=1 negates.
// Latency: combinational.
// Backpressure: none.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             inv,
    input  logic             inc,
    output logic [WIDTH-1:0] res
);
    assign res = (val ^ {WIDTH{inv}}) + {{(WIDTH-1){1'b0}}, inc};
endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed/unsigned multiply/divide, one bit per cycle; abort port under MULDIV_ABORT_EN.
// Latency: done WIDTH+2 edges after the start edge; divide-by-zero done right after the start edge.
// Backpressure: starts outside IDLE are dropped, no queueing; min issue interval WIDTH+3.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    state_t               state, nextState;
    op_t                  opQ;
    logic                 signedQ, prodNeg, remNeg, dbzQ;
    logic [WIDTH-1:0]     aQ, bQ, mOp, rem, hiQ, loQ;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 abortReq, startAny, signA, signB;
    logic                 busyC, doneC;
    logic [WIDTH:0]       mulSum, divShift, divDiff;
    logic [WIDTH-1:0]     fixLoIn, fixHiIn, fixLoOut, fixHiOut;
    logic                 fixLoInv, fixHiInv, fixHiInc;

`ifdef MULDIV_ABORT_EN
    assign abortReq = bus.abort & isBusyState(state);
`else
    assign abortReq = 1'b0;
`endif

    assign startAny = bus.start_mult | bus.start_div;
    assign signA    = signedQ & aQ[WIDTH-1];
    assign signB    = signedQ & bQ[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        busyC     = isBusyState(state);
        doneC     = (state == DONE);
        case (state)
            IDLE: begin
                if (bus.start_mult)     nextState = PREP;
                else if (bus.start_div) nextState = (bus.b == '0) ? DONE : PREP;
            end
            PREP:    nextState = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) nextState = FIX;
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abortReq) nextState = IDLE;
    end

    assign bus.busy        = busyC;
    assign bus.done        = doneC;
    assign bus.div_by_zero = doneC & dbzQ;
    assign bus.hi          = hiQ;
    assign bus.lo          = loQ;

    // The two negators take operand magnitudes in PREP and correct result signs in FIX.
    always_comb begin
        fixLoIn  = acc[WIDTH-1:0];
        fixLoInv = prodNeg;
        fixHiIn  = (opQ == OP_MULT) ? acc[2*WIDTH-1:WIDTH] : rem;
        fixHiInv = (opQ == OP_MULT) ? prodNeg : remNeg;
        // Upper product half only absorbs the +1 when the lower half is all zeros.
        fixHiInc = (opQ == OP_MULT) ? (prodNeg & (acc[WIDTH-1:0] == '0)) : remNeg;
        if (state == PREP) begin
            fixLoIn  = aQ;
            fixLoInv = signA;
            fixHiIn  = bQ;
            fixHiInv = signB;
            fixHiInc = signB;
        end
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) uFixLo (
        .val(fixLoIn), .inv(fixLoInv), .inc(fixLoInv), .res(fixLoOut)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) uFixHi (
        .val(fixHiIn), .inv(fixHiInv), .inc(fixHiInc), .res(fixHiOut)
    );

    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mOp} : '0);
    assign divShift = {rem, acc[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, mOp};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opQ     <= OP_MULT;
            signedQ <= 1'b0;
            prodNeg <= 1'b0;
            remNeg  <= 1'b0;
            dbzQ    <= 1'b0;
            aQ      <= '0;
            bQ      <= '0;
            mOp     <= '0;
            rem     <= '0;
            acc     <= '0;
            cnt     <= '0;
            hiQ     <= '0;
            loQ     <= '0;
        end else begin
            case (state)
                IDLE: if (startAny) begin
                    opQ     <= bus.start_mult ? OP_MULT : OP_DIV;
                    signedQ <= bus.is_signed;
                    aQ      <= bus.a;
                    bQ      <= bus.b;
                    dbzQ    <= ~bus.start_mult & (bus.b == '0);
                end
                PREP: begin
                    cnt     <= '0;
                    rem     <= '0;
                    prodNeg <= signA ^ signB;
                    remNeg  <= signA;
                    if (opQ == OP_MULT) begin
                        mOp <= fixLoOut;
                        acc <= {{WIDTH{1'b0}}, fixHiOut};
                    end else begin
                        mOp <= fixHiOut;
                        acc <= {{WIDTH{1'b0}}, fixLoOut};
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (opQ == OP_MULT) begin
                        acc <= {mulSum, acc[WIDTH-1:1]};
                    end else begin
                        // Restoring step: a clear borrow bit means the divisor fitted.
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~divDiff[WIDTH]};
                        rem            <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
                    end
                end
                FIX: if (!abortReq) begin
                    hiQ <= fixHiOut;
                    loQ <= fixLoOut;
                end
                default: ;
            endcase
        end
    end

endmodule
